// File: rtl/pcs_4b5b_pkg.sv
// Shared 100BASE-X PCS definitions: transmit FSM states, control code groups
// and the 4B5B data code table.
package pcs_4b5b_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_J,
    ST_K,
    ST_DATA,
    ST_T,
    ST_R,
    ST_DROP
  } tx_state_t;

  localparam logic [4:0] CODE_I = 5'b11111;
  localparam logic [4:0] CODE_J = 5'b11000;
  localparam logic [4:0] CODE_K = 5'b10001;
  localparam logic [4:0] CODE_T = 5'b01101;
  localparam logic [4:0] CODE_R = 5'b00111;

  function automatic logic [4:0] enc4b5b(input logic [3:0] nibble);
    logic [4:0] code;
    case (nibble)
      4'h0:    code = 5'b11110;
      4'h1:    code = 5'b01001;
      4'h2:    code = 5'b10100;
      4'h3:    code = 5'b10101;
      4'h4:    code = 5'b01010;
      4'h5:    code = 5'b01011;
      4'h6:    code = 5'b01110;
      4'h7:    code = 5'b01111;
      4'h8:    code = 5'b10010;
      4'h9:    code = 5'b10011;
      4'hA:    code = 5'b10110;
      4'hB:    code = 5'b10111;
      4'hC:    code = 5'b11010;
      4'hD:    code = 5'b11011;
      4'hE:    code = 5'b11100;
      default: code = 5'b11101;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/nrzi_enc5.sv
// 5-bit parallel NRZI encoder; bit 4 is the first bit on the line and the
// final line level is carried into the next word.
module nrzi_enc5 #(
  parameter logic INIT_LEVEL = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_res_n,
  input  logic [4:0] i_code,
  output logic [4:0] o_nrzi
);

  logic       level_reg;
  logic [4:0] nrzi_reg;
  logic [4:0] nrzi_next;
  logic       lvl;

  // A one toggles the line, a zero holds it; walk MSB first.
  always_comb begin
    lvl       = level_reg;
    nrzi_next = 5'b00000;
    for (int k = 4; k >= 0; k--) begin
      lvl          = lvl ^ i_code[k];
      nrzi_next[k] = lvl;
    end
  end

  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      level_reg <= INIT_LEVEL;
      nrzi_reg  <= 5'b00000;
    end else begin
      level_reg <= nrzi_next[0];
      nrzi_reg  <= nrzi_next;
    end
  end

  assign o_nrzi = nrzi_reg;

endmodule

// File: rtl/tx_4b5b_nrzi_enc.sv
// 100BASE-X transmit PCS: wraps MII nibbles in /J/K/ ... /T/R/, fills gaps
// with /I/, and NRZI-encodes each code group for the serializer.
module tx_4b5b_nrzi_enc
  import pcs_4b5b_pkg::*;
#(
  parameter int   CNT_W      = 16,
  parameter logic INIT_LEVEL = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_res_n,
  input  logic             i_tx_en,
  input  logic [3:0]       i_tx_data,
  output logic [4:0]       o_code,
  output logic [4:0]       o_nrzi,
  output logic             o_busy,
  output logic             o_tx_err,
  output logic [CNT_W-1:0] o_frame_cnt
);

  tx_state_t        state_reg;
  logic [4:0]       code_reg;
  logic             busy_reg;
  logic             err_reg;
  logic [CNT_W-1:0] cnt_reg;

  // state_reg names the code group currently held in code_reg, so a sample
  // at edge n selects the code group presented after edge n.
  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      state_reg <= ST_IDLE;
      code_reg  <= CODE_I;
      busy_reg  <= 1'b0;
      err_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      err_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (i_tx_en) begin
            state_reg <= ST_J;
            code_reg  <= CODE_J;
            busy_reg  <= 1'b1;
          end else begin
            code_reg  <= CODE_I;
            busy_reg  <= 1'b0;
          end
        end
        ST_J: begin
          busy_reg <= 1'b1;
          if (i_tx_en) begin
            state_reg <= ST_K;
            code_reg  <= CODE_K;
          end else begin
            state_reg <= ST_T;
            code_reg  <= CODE_T;
          end
        end
        ST_K, ST_DATA: begin
          busy_reg <= 1'b1;
          if (i_tx_en) begin
            state_reg <= ST_DATA;
            code_reg  <= enc4b5b(i_tx_data);
          end else begin
            state_reg <= ST_T;
            code_reg  <= CODE_T;
          end
        end
        ST_T: begin
          // tx_en back high while the end-of-stream is still going out is an
          // IPG violation; R is sent regardless and the new frame dropped.
          state_reg <= ST_R;
          code_reg  <= CODE_R;
          busy_reg  <= 1'b1;
          err_reg   <= i_tx_en;
          cnt_reg   <= cnt_reg + CNT_W'(1);
        end
        ST_R: begin
          state_reg <= err_reg ? ST_DROP : ST_IDLE;
          code_reg  <= CODE_I;
          busy_reg  <= 1'b0;
        end
        ST_DROP: begin
          state_reg <= i_tx_en ? ST_DROP : ST_IDLE;
          code_reg  <= CODE_I;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= ST_IDLE;
          code_reg  <= CODE_I;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  nrzi_enc5 #(
    .INIT_LEVEL(INIT_LEVEL)
  ) u_nrzi (
    .i_clk  (i_clk),
    .i_res_n(i_res_n),
    .i_code (code_reg),
    .o_nrzi (o_nrzi)
  );

  assign o_code      = code_reg;
  assign o_busy      = busy_reg;
  assign o_tx_err    = err_reg;
  assign o_frame_cnt = cnt_reg;

endmodule
